// File: rtl/spdif_subframe_unpack.sv
// rtl/spdif_subframe_unpack.sv - S/PDIF subframe unpacker with preamble tracking, parity and channel status.
module spdif_subframe_unpack #(
    parameter int SAMPLE_W  = 20,
    parameter int NUM_CH    = 2,
    parameter int FRAMES    = 192,
    parameter int ERR_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vin,
    input  logic                din,
    input  logic                sof,
    input  logic [1:0]          pre,
    output logic [SAMPLE_W-1:0] sample_dout,
    output logic [2:0]          sample_ch,
    output logic [2:0]          sample_flags,
    output logic                sample_vout,
    output logic [3:0]          aux_dout,
    output logic [FRAMES-1:0]   cs_dout,
    output logic [2:0]          cs_ch,
    output logic                cs_vout,
    output logic [7:0]          frame_idx,
    output logic                locked,
    output logic                kill
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FR_W = $clog2(FRAMES);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAMES - 1);
    localparam logic [1:0] PRE_Z = 2'd0;
    localparam logic [1:0] PRE_X = 2'd1;
    localparam logic [1:0] PRE_Y = 2'd2;

    typedef enum logic [1:0] {HUNT, SHIFT, CHECK, WAIT} state_t;

    state_t                           state_q;
    logic [27:0]                      sr_q;
    logic [4:0]                       bit_cnt_q;
    logic [CH_W-1:0]                  ch_q;
    logic [FR_W-1:0]                  frame_q;
    logic [3:0]                       err_cnt_q;
    logic [NUM_CH-1:0][FRAMES-1:0]    shadow_q;
    logic [SAMPLE_W-1:0]              sample_dout_q;
    logic [2:0]                       sample_ch_q;
    logic [2:0]                       sample_flags_q;
    logic                             sample_vout_q;
    logic [3:0]                       aux_q;
    logic [FRAMES-1:0]                cs_dout_q;
    logic [2:0]                       cs_ch_q;
    logic                             cs_vout_q;
    logic                             locked_q;
    logic                             kill_q;

    logic                             par_err;
    logic [4:0]                       err_inc;
    logic                             ch_wrap;
    logic                             fr_last;
    logic [CH_W-1:0]                  ch_nxt;
    logic [FR_W-1:0]                  fr_nxt;
    logic [1:0]                       exp_pre;
    logic [FRAMES-1:0]                cs_word;
    logic                             start_d;
    logic                             shift_d;
    logic                             kill_d;

    always_comb begin
        par_err = ^sr_q;
        err_inc = {1'b0, err_cnt_q} + 5'd1;
        ch_wrap = (ch_q == CH_LAST);
        fr_last = (frame_q == FR_LAST);
        ch_nxt  = ch_wrap ? '0 : ch_q + CH_W'(1);
        fr_nxt  = frame_q;
        if (ch_wrap) begin
            fr_nxt = fr_last ? '0 : frame_q + FR_W'(1);
        end
        // ch_q/frame_q already point at the subframe we are waiting for
        if (ch_q == '0) begin
            exp_pre = (frame_q == '0) ? PRE_Z : PRE_X;
        end else begin
            exp_pre = PRE_Y;
        end
        cs_word = shadow_q[ch_q];
        cs_word[FRAMES-1] = sr_q[26];
    end

    // start_d: the sof of this cycle is accepted as data bit 0 (lock, continue or relock on Z)
    always_comb begin
        start_d = 1'b0;
        shift_d = 1'b0;
        kill_d  = 1'b0;
        case (state_q)
            HUNT: start_d = vin && sof && (pre == PRE_Z);
            SHIFT: begin
                shift_d = vin && !sof;
                kill_d  = vin && sof;
                start_d = vin && sof && (pre == PRE_Z);
            end
            CHECK: kill_d = par_err && (err_inc >= 5'(ERR_LIMIT));
            WAIT: begin
                if (vin && sof) begin
                    kill_d  = (pre != exp_pre);
                    start_d = (pre == exp_pre) || (pre == PRE_Z);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HUNT;
            sr_q           <= '0;
            bit_cnt_q      <= '0;
            ch_q           <= '0;
            frame_q        <= '0;
            err_cnt_q      <= '0;
            shadow_q       <= '0;
            sample_dout_q  <= '0;
            sample_ch_q    <= '0;
            sample_flags_q <= '0;
            sample_vout_q  <= 1'b0;
            aux_q          <= '0;
            cs_dout_q      <= '0;
            cs_ch_q        <= '0;
            cs_vout_q      <= 1'b0;
            locked_q       <= 1'b0;
            kill_q         <= 1'b0;
        end else begin
            sample_vout_q <= 1'b0;
            cs_vout_q     <= 1'b0;
            kill_q        <= 1'b0;
            if (state_q == SHIFT) begin
                locked_q <= 1'b1;
            end
            if (start_d) begin
                sr_q      <= {din, sr_q[27:1]};
                bit_cnt_q <= 5'd1;
                state_q   <= SHIFT;
                if (pre == PRE_Z) begin
                    ch_q     <= '0;
                    frame_q  <= '0;
                    locked_q <= 1'b1;
                end
            end else if (shift_d) begin
                sr_q      <= {din, sr_q[27:1]};
                bit_cnt_q <= bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd27) begin
                    state_q <= CHECK;
                end
            end
            if (state_q == CHECK) begin
                sample_vout_q  <= 1'b1;
                sample_dout_q  <= sr_q[24-SAMPLE_W +: SAMPLE_W];
                sample_ch_q    <= 3'(ch_q);
                sample_flags_q <= {sr_q[24], sr_q[25], par_err};
                aux_q          <= (SAMPLE_W <= 20) ? sr_q[3:0] : 4'd0;
                shadow_q[ch_q][frame_q] <= sr_q[26];
                if (fr_last) begin
                    cs_vout_q <= 1'b1;
                    cs_dout_q <= cs_word;
                    cs_ch_q   <= 3'(ch_q);
                end
                ch_q      <= ch_nxt;
                frame_q   <= fr_nxt;
                err_cnt_q <= par_err ? err_inc[3:0] : 4'd0;
                state_q   <= WAIT;
            end
            // a relock keeps the SHIFT entered above; locked rises again next cycle
            if (kill_d) begin
                kill_q    <= 1'b1;
                locked_q  <= 1'b0;
                shadow_q  <= '0;
                err_cnt_q <= '0;
                if (!start_d) begin
                    state_q <= HUNT;
                end
            end
        end
    end

    assign sample_dout  = sample_dout_q;
    assign sample_ch    = sample_ch_q;
    assign sample_flags = sample_flags_q;
    assign sample_vout  = sample_vout_q;
    assign aux_dout     = aux_q;
    assign cs_dout      = cs_dout_q;
    assign cs_ch        = cs_ch_q;
    assign cs_vout      = cs_vout_q;
    assign frame_idx    = 8'(frame_q);
    assign locked       = locked_q;
    assign kill         = kill_q;

endmodule

// File: tb/tb_spdif_subframe_unpack.sv
// tb/tb_spdif_subframe_unpack.sv - directed table-driven bench for spdif_subframe_unpack.
module tb_spdif_subframe_unpack;

    logic clk = 1'b0;
    logic rst, vin, din, sof;
    logic [1:0] pre;

    logic [19:0]  s_dout;
    logic [2:0]   s_ch, s_flags, c_ch;
    logic         s_vout, c_vout, lck, kil;
    logic [3:0]   aux;
    logic [191:0] c_dout;
    logic [7:0]   fidx;

    logic [15:0]  t_dout;
    logic [2:0]   t_ch, t_flags, tc_ch;
    logic         t_vout, tc_vout, t_lck, t_kil;
    logic [3:0]   t_aux;
    logic [191:0] tc_dout;
    logic [7:0]   t_fidx;

    spdif_subframe_unpack #(.SAMPLE_W(20)) dut (
        .clk(clk), .rst(rst), .vin(vin), .din(din), .sof(sof), .pre(pre),
        .sample_dout(s_dout), .sample_ch(s_ch), .sample_flags(s_flags), .sample_vout(s_vout),
        .aux_dout(aux), .cs_dout(c_dout), .cs_ch(c_ch), .cs_vout(c_vout),
        .frame_idx(fidx), .locked(lck), .kill(kil)
    );

    spdif_subframe_unpack #(.SAMPLE_W(16)) dut16 (
        .clk(clk), .rst(rst), .vin(vin), .din(din), .sof(sof), .pre(pre),
        .sample_dout(t_dout), .sample_ch(t_ch), .sample_flags(t_flags), .sample_vout(t_vout),
        .aux_dout(t_aux), .cs_dout(tc_dout), .cs_ch(tc_ch), .cs_vout(tc_vout),
        .frame_idx(t_fidx), .locked(t_lck), .kill(t_kil)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int vcnt = 0, kcnt = 0, cscnt = 0;
    logic [191:0] cs_log_d [4];
    logic [2:0]   cs_log_ch [4];

    always @(negedge clk) begin
        if (s_vout) vcnt++;
        if (kil) kcnt++;
        if (c_vout) begin
            if (cscnt < 4) begin
                cs_log_d[cscnt]  = c_dout;
                cs_log_ch[cscnt] = c_ch;
            end
            cscnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_w(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [27:0] mk(input logic [3:0] a, input logic [19:0] au,
                                       input logic v, input logic u, input logic c, input logic bad);
        logic [26:0] b;
        b = {c, u, v, au, a};
        return {(^b) ^ bad, b};
    endfunction

    task automatic send(input logic [1:0] p, input logic [27:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vin = 1'b1;
            sof = (k == 0);
            pre = p;
            din = w[k];
        end
        @(negedge clk);
        vin = 1'b0;
        sof = 1'b0;
        din = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  p;
        logic [3:0]  a;
        logic [19:0] au;
        logic        v, u, c, bad;
        logic [19:0] e20;
        logic [15:0] e16;
        logic [2:0]  ech, efl;
        logic [7:0]  efr;
    } vec_t;

    vec_t tbl [5];
    int v0, k0, c0;

    initial begin
        rst = 1'b1; vin = 1'b0; din = 1'b0; sof = 1'b0; pre = 2'd0;
        tbl[0] = '{2'd0, 4'h0, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 20'hFFFFF, 16'hFFFF, 3'd0, 3'b000, 8'd0};
        tbl[1] = '{2'd2, 4'hA, 20'h12345, 1'b1, 1'b0, 1'b0, 1'b0, 20'h12345, 16'h1234, 3'd1, 3'b100, 8'd1};
        tbl[2] = '{2'd1, 4'h5, 20'hABCDE, 1'b0, 1'b1, 1'b0, 1'b0, 20'hABCDE, 16'hABCD, 3'd0, 3'b010, 8'd1};
        tbl[3] = '{2'd2, 4'hF, 20'h00001, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00001, 16'h0000, 3'd1, 3'b001, 8'd2};
        tbl[4] = '{2'd1, 4'h0, 20'h80000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h80000, 16'h8000, 3'd0, 3'b000, 8'd2};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sample", 32'(s_dout), 32'h0);
        chk("rst_locked", 32'(lck), 32'h0);
        chk("rst_frame", 32'(fidx), 32'h0);
        chk_w("rst_cs", c_dout, 192'h0);

        for (int i = 0; i < 5; i++) begin
            v0 = vcnt; k0 = kcnt;
            send(tbl[i].p, mk(tbl[i].a, tbl[i].au, tbl[i].v, tbl[i].u, tbl[i].c, tbl[i].bad), 28);
            chk($sformatf("t%0d_vout", i), 32'(vcnt), 32'(v0 + 1));
            chk($sformatf("t%0d_s20", i), 32'(s_dout), 32'(tbl[i].e20));
            chk($sformatf("t%0d_s16", i), 32'(t_dout), 32'(tbl[i].e16));
            chk($sformatf("t%0d_ch", i), 32'(s_ch), 32'(tbl[i].ech));
            chk($sformatf("t%0d_flags", i), 32'(s_flags), 32'(tbl[i].efl));
            chk($sformatf("t%0d_aux", i), 32'(aux), 32'(tbl[i].a));
            chk($sformatf("t%0d_frame", i), 32'(fidx), 32'(tbl[i].efr));
            chk($sformatf("t%0d_locked", i), 32'(lck), 32'h1);
            chk($sformatf("t%0d_kill", i), 32'(kcnt), 32'(k0));
        end

        // full block: C=1 on frame 0 only
        do_reset();
        v0 = vcnt; k0 = kcnt; c0 = cscnt;
        for (int f = 0; f < 192; f++) begin
            for (int c = 0; c < 2; c++) begin
                send((c == 1) ? 2'd2 : ((f == 0) ? 2'd0 : 2'd1),
                     mk(4'h3, 20'(f * 3 + c), 1'b0, 1'b0, (f == 0), 1'b0), 28);
                if (f == 191 && c == 0) chk("blk_frame191", 32'(fidx), 32'd191);
            end
        end
        chk("blk_vout", 32'(vcnt), 32'(v0 + 384));
        chk("blk_kill", 32'(kcnt), 32'(k0));
        chk("blk_cs_cnt", 32'(cscnt), 32'(c0 + 2));
        chk("blk_cs0_ch", 32'(cs_log_ch[0]), 32'd0);
        chk_w("blk_cs0_d", cs_log_d[0], 192'h1);
        chk("blk_cs1_ch", 32'(cs_log_ch[1]), 32'd1);
        chk_w("blk_cs1_d", cs_log_d[1], 192'h1);
        chk("blk_wrap", 32'(fidx), 32'd0);

        // three consecutive parity errors
        k0 = kcnt;
        send(2'd0, mk(4'h0, 20'h11111, 1'b0, 1'b0, 1'b0, 1'b1), 28);
        chk("par1_flag", 32'(s_flags), 32'b001);
        chk("par1_kill", 32'(kcnt), 32'(k0));
        send(2'd2, mk(4'h0, 20'h22222, 1'b0, 1'b0, 1'b0, 1'b1), 28);
        chk("par2_flag", 32'(s_flags), 32'b001);
        chk("par2_kill", 32'(kcnt), 32'(k0));
        v0 = vcnt;
        send(2'd1, mk(4'h0, 20'h33333, 1'b0, 1'b0, 1'b0, 1'b1), 28);
        chk("par3_vout", 32'(vcnt), 32'(v0 + 1));
        chk("par3_flag", 32'(s_flags), 32'b001);
        chk("par3_kill", 32'(kcnt), 32'(k0 + 1));
        chk("par3_locked", 32'(lck), 32'h0);
        v0 = vcnt;
        send(2'd0, mk(4'h0, 20'h44444, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("par_relock_vout", 32'(vcnt), 32'(v0 + 1));
        chk("par_relock_lck", 32'(lck), 32'h1);
        chk("par_relock_flag", 32'(s_flags), 32'b000);

        // X where Y expected
        v0 = vcnt; k0 = kcnt;
        send(2'd1, mk(4'h0, 20'h55555, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("pv_kill", 32'(kcnt), 32'(k0 + 1));
        chk("pv_vout", 32'(vcnt), 32'(v0));
        chk("pv_locked", 32'(lck), 32'h0);
        send(2'd2, mk(4'h0, 20'h66666, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("pv_hunt_vout", 32'(vcnt), 32'(v0));
        send(2'd0, mk(4'h0, 20'h77777, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("pv_z_vout", 32'(vcnt), 32'(v0 + 1));
        chk("pv_z_sample", 32'(s_dout), 32'h77777);
        send(2'd2, mk(4'h0, 20'h88888, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("pv_y_frame", 32'(fidx), 32'd1);
        // Z mid-block: kill and immediate relock
        v0 = vcnt; k0 = kcnt;
        send(2'd0, mk(4'h0, 20'h99999, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("zm_kill", 32'(kcnt), 32'(k0 + 1));
        chk("zm_vout", 32'(vcnt), 32'(v0 + 1));
        chk("zm_sample", 32'(s_dout), 32'h99999);
        chk("zm_ch", 32'(s_ch), 32'd0);
        chk("zm_frame", 32'(fidx), 32'd0);
        chk("zm_locked", 32'(lck), 32'h1);

        // truncated subframe: sof after 10 bits
        v0 = vcnt; k0 = kcnt;
        send(2'd2, mk(4'h0, 20'hAAAAA, 1'b0, 1'b0, 1'b0, 1'b0), 10);
        send(2'd1, mk(4'h0, 20'hBBBBB, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("tr_kill", 32'(kcnt), 32'(k0 + 1));
        chk("tr_vout", 32'(vcnt), 32'(v0));
        chk("tr_locked", 32'(lck), 32'h0);

        // illegal preamble while locked
        send(2'd0, mk(4'h0, 20'h12121, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        v0 = vcnt; k0 = kcnt;
        send(2'd3, mk(4'h0, 20'h34343, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("ill_kill", 32'(kcnt), 32'(k0 + 1));
        chk("ill_vout", 32'(vcnt), 32'(v0));

        // reset mid-SHIFT
        send(2'd0, mk(4'h7, 20'hABCDE, 1'b1, 1'b1, 1'b0, 1'b0), 28);
        chk("pre_rst_s16", 32'(t_dout), 32'hABCD);
        send(2'd2, mk(4'h0, 20'h5A5A5, 1'b0, 1'b0, 1'b0, 1'b0), 10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_sample", 32'(s_dout), 32'h0);
        chk("mr_s16", 32'(t_dout), 32'h0);
        chk("mr_flags", 32'(s_flags), 32'h0);
        chk("mr_ch", 32'(s_ch), 32'h0);
        chk("mr_aux", 32'(aux), 32'h0);
        chk("mr_frame", 32'(fidx), 32'h0);
        chk("mr_locked", 32'(lck), 32'h0);
        v0 = vcnt;
        send(2'd2, mk(4'h0, 20'h5A5A5, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("mr_hunt_vout", 32'(vcnt), 32'(v0));
        send(2'd0, mk(4'h2, 20'h0F0F0, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        chk("mr_relock_vout", 32'(vcnt), 32'(v0 + 1));
        chk("mr_relock_s", 32'(s_dout), 32'h0F0F0);
        chk("mr_relock_aux", 32'(aux), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
